// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU controller: command codes, ALU op codes and FSM states.
// ALU_CTRL_MUL_EN decides whether the MUL command is legal.
package alu_ctrl_pkg;

  localparam logic [3:0] CMD_LDA  = 4'b1000;
  localparam logic [3:0] CMD_LDB  = 4'b1001;
  localparam logic [3:0] CMD_SWAP = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1011;

  // Op bit 2 is op0 (the MSB of the op field).
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SUM  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_TWOS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic isIllegal(input logic [3:0] code);
`ifdef ALU_CTRL_MUL_EN
    return (code[3:2] == 2'b11);
`else
    return (code[3:2] == 2'b11) || (code == CMD_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_controller_alu.sv
// The 4-bit combinational ALU owned by alu_controller.
// Bit 3 of every vector is the x0/y0/out0 MSB; carry is 0 for the logic ops.
module ALU
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic [2:0] op_i,
  output logic [3:0] out_o,
  output logic       carry_o
);

  logic [4:0] sum;
  logic [4:0] diff;
  logic [4:0] neg;

  // SUB and TWOS carry out of the inverted-operand-plus-one adder (1 means no borrow).
  assign sum  = {1'b0, x_i} + {1'b0, y_i};
  assign diff = {1'b0, x_i} + {1'b0, ~y_i} + 5'd1;
  assign neg  = {1'b0, ~x_i} + 5'd1;

  always_comb begin
    out_o   = 4'h0;
    carry_o = 1'b0;
    case (op_i)
      OP_AND:  out_o = x_i & y_i;
      OP_NOT:  out_o = ~x_i;
      OP_OR:   out_o = x_i | y_i;
      OP_XOR:  out_o = x_i ^ y_i;
      OP_SHL:  {carry_o, out_o} = {x_i, 1'b0};
      OP_SUM:  {carry_o, out_o} = sum;
      OP_SUB:  {carry_o, out_o} = diff;
      OP_TWOS: {carry_o, out_o} = neg;
      default: out_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Command sequencer around the 4-bit ALU: loads, single ALU ops and a shift-add multiply.
// Define ALU_CTRL_MUL_EN to build the MUL command; otherwise code 1011 is illegal.
module alu_controller
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_code,
  input  logic [3:0] cmd_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       err,
  output logic [3:0] acc_a,
  output logic [3:0] acc_b
);

  state_e     state_q, state_d;
  logic [3:0] accA_q, accB_q;
  logic [2:0] op_q;
  logic       flag_q;
  logic       err_q;
  logic [7:0] resData_q;

  logic       cmdFire;
  logic [3:0] aluX, aluY, aluOut;
  logic [2:0] aluOp;
  logic       aluCarry;

  assign cmdFire = cmd_valid && cmd_ready;

`ifdef ALU_CTRL_MUL_EN
  logic [3:0] m_q, pHi_q, pLo_q;
  logic [1:0] cnt_q;
  logic [3:0] pHiAdd, pHiNext, pLoNext;
  logic       mulC;

  // One iteration: conditional add into P_hi, then shift {c, P_hi, P_lo} right by one.
  assign pHiAdd  = pLo_q[0] ? aluOut : pHi_q;
  assign mulC    = pLo_q[0] & aluCarry;
  assign pHiNext = {mulC, pHiAdd[3:1]};
  assign pLoNext = {pHiAdd[0], pLo_q[3:1]};

  assign aluX  = (state_q == ST_MUL) ? pHi_q  : accA_q;
  assign aluY  = (state_q == ST_MUL) ? m_q    : accB_q;
  assign aluOp = (state_q == ST_MUL) ? OP_SUM : op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= 4'h0;
      pHi_q <= 4'h0;
      pLo_q <= 4'h0;
      cnt_q <= 2'd0;
    end else if (state_q == ST_IDLE && cmdFire && cmd_code == CMD_MUL) begin
      m_q   <= accA_q;
      pHi_q <= 4'h0;
      pLo_q <= accB_q;
      cnt_q <= 2'd0;
    end else if (state_q == ST_MUL) begin
      pHi_q <= pHiNext;
      pLo_q <= pLoNext;
      cnt_q <= cnt_q + 2'd1;
    end
  end
`else
  assign aluX  = accA_q;
  assign aluY  = accB_q;
  assign aluOp = op_q;
`endif

  ALU uAlu (
    .x_i    (aluX),
    .y_i    (aluY),
    .op_i   (aluOp),
    .out_o  (aluOut),
    .carry_o(aluCarry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmdFire && !cmd_code[3]) state_d = ST_EXEC;
`ifdef ALU_CTRL_MUL_EN
        else if (cmdFire && cmd_code == CMD_MUL) state_d = ST_MUL;
`endif
      end
      ST_EXEC: state_d = ST_RESP;
`ifdef ALU_CTRL_MUL_EN
      ST_MUL:  if (cnt_q == 2'd3) state_d = ST_RESP;
`endif
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !reset;
    res_valid = (state_q == ST_RESP);
  end

  // Accumulators, result holding register and the error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accA_q    <= 4'h0;
      accB_q    <= 4'h0;
      op_q      <= 3'd0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      resData_q <= 8'h00;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmdFire) begin
            if (isIllegal(cmd_code)) begin
              err_q <= 1'b1;
            end else if (!cmd_code[3]) begin
              op_q <= cmd_code[2:0];
            end else begin
              case (cmd_code)
                CMD_LDA:  accA_q <= cmd_data;
                CMD_LDB:  accB_q <= cmd_data;
                CMD_SWAP: begin
                  accA_q <= accB_q;
                  accB_q <= accA_q;
                end
                default: ;
              endcase
            end
          end
        end
        ST_EXEC: begin
          accA_q    <= aluOut;
          flag_q    <= aluCarry;
          resData_q <= {4'h0, aluOut};
        end
`ifdef ALU_CTRL_MUL_EN
        ST_MUL: begin
          if (cnt_q == 2'd3) begin
            accA_q    <= pHiNext;
            accB_q    <= pLoNext;
            flag_q    <= 1'b0;
            resData_q <= {pHiNext, pLoNext};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign res_data  = resData_q;
  assign res_carry = flag_q;
  assign err       = err_q;
  assign acc_a     = accA_q;
  assign acc_b     = accB_q;

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: arithmetic reference model plus per-cycle compare.
// Honours ALU_CTRL_MUL_EN the same way as the design.
module tb_alu_controller;

  localparam logic [3:0] LDA  = 4'b1000;
  localparam logic [3:0] LDB  = 4'b1001;
  localparam logic [3:0] SWAP = 4'b1010;
  localparam logic [3:0] MUL  = 4'b1011;
`ifdef ALU_CTRL_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_code, cmd_data;
  logic       res_valid, res_ready, res_carry, err;
  logic [7:0] res_data;
  logic [3:0] acc_a, acc_b;

  logic [3:0] mA, mB;
  logic       mRdy, mValid, mCarry, mErr;
  logic [7:0] mData;
  int         checks = 0;
  int         errors = 0;
  bit         checkEn = 1'b0;

  logic [7:0] d;
  logic       c;

  alu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code (cmd_code),
    .cmd_data (cmd_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_carry(res_carry),
    .err      (err),
    .acc_a    (acc_a),
    .acc_b    (acc_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Returns {carry, out}; carry of SUB/TWOS means "no borrow".
  function automatic logic [4:0] aluModel(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    int xi = int'(x);
    int yi = int'(y);
    case (op)
      3'b000:  return {1'b0, x & y};
      3'b001:  return {1'b0, ~x};
      3'b010:  return {1'b0, x | y};
      3'b011:  return {1'b0, x ^ y};
      3'b100:  return 5'(xi * 2);
      3'b101:  return 5'(xi + yi);
      3'b110:  return {xi >= yi, 4'(xi - yi)};
      default: return {xi == 0, 4'(16 - xi)};
    endcase
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("acc_a", 8'(acc_a), 8'(mA));
      checkOutput("acc_b", 8'(acc_b), 8'(mB));
      checkOutput("cmd_ready", 8'(cmd_ready), 8'(mRdy));
      checkOutput("res_valid", 8'(res_valid), 8'(mValid));
      checkOutput("err", 8'(err), 8'(mErr));
      if (mValid) begin
        checkOutput("res_data", res_data, mData);
        checkOutput("res_carry", 8'(res_carry), 8'(mCarry));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] code, input logic [3:0] data, input int hold,
                               output logic [7:0] gotData, output logic gotCarry);
    logic [4:0] r;
    logic [7:0] p;
    gotData   = 8'h00;
    gotCarry  = 1'b0;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    res_ready = (hold == 0);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    if (!code[3]) begin
      r    = aluModel(code[2:0], mA, mB);
      mRdy = 1'b0;
      tick();
      mA     = r[3:0];
      mValid = 1'b1;
      mData  = {4'h0, r[3:0]};
      mCarry = r[4];
    end else if (code == LDA) begin
      mA = data;
    end else if (code == LDB) begin
      mB = data;
    end else if (code == SWAP) begin
      {mA, mB} = {mB, mA};
    end else if (code == MUL && MulEn) begin
      p    = 8'(mA) * 8'(mB);
      mRdy = 1'b0;
      repeat (4) tick();
      mA     = p[7:4];
      mB     = p[3:0];
      mValid = 1'b1;
      mData  = p;
      mCarry = 1'b0;
    end else begin
      mErr = 1'b1;
      tick();
      mErr = 1'b0;
    end
    if (mValid) begin
      gotData  = res_data;
      gotCarry = res_carry;
      for (int i = 0; i < hold; i++) begin
        cmd_valid = 1'b1;
        cmd_code  = LDA;
        cmd_data  = 4'hF;
        tick();
      end
      res_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      mValid    = 1'b0;
      mRdy      = 1'b1;
    end
  endtask

  task automatic resetMid(input logic [3:0] code, input int cyclesIn);
    cmd_valid = 1'b1;
    cmd_code  = code;
    res_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    mRdy      = 1'b0;
    repeat (cyclesIn) tick();
    reset  = 1'b1;
    mA     = 4'h0;
    mB     = 4'h0;
    mValid = 1'b0;
    mErr   = 1'b0;
    #1;
    checkOutput("abort_res_valid", 8'(res_valid), 8'h00);
    checkOutput("abort_acc_a", 8'(acc_a), 8'h00);
    checkOutput("abort_cmd_ready", 8'(cmd_ready), 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    mRdy  = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] xs [3] = '{4'h9, 4'h0, 4'h3};
  logic [3:0] ys [3] = '{4'h3, 4'h5, 4'h9};

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 4'h0;
    cmd_data  = 4'h0;
    res_ready = 1'b0;
    mA = 4'h0; mB = 4'h0; mRdy = 1'b0; mValid = 1'b0; mCarry = 1'b0; mErr = 1'b0; mData = 8'h00;
    checkEn = 1'b1;
    repeat (2) tick();
    checkOutput("rst_res_data", res_data, 8'h00);
    checkOutput("rst_res_carry", 8'(res_carry), 8'h00);
    reset = 1'b0;
    mRdy  = 1'b1;
    tick();

    $display("[TB] SUM with res_ready held high early");
    applyStimulus(LDA, 4'b0111, 0, d, c);
    applyStimulus(LDB, 4'b1110, 0, d, c);
    applyStimulus(4'b0101, 4'h0, 0, d, c);
    checkOutput("sum_data", d, 8'h05);
    checkOutput("sum_carry", 8'(c), 8'h01);
    checkOutput("sum_acc_a", 8'(acc_a), 8'h05);

    $display("[TB] SHL with a 5-cycle result stall");
    applyStimulus(LDA, 4'b0111, 0, d, c);
    applyStimulus(4'b0100, 4'h0, 5, d, c);
    checkOutput("shl_data", d, 8'h0E);
    checkOutput("shl_carry", 8'(c), 8'h00);

    $display("[TB] MUL 7 x 14");
    applyStimulus(LDA, 4'b0111, 0, d, c);
    applyStimulus(LDB, 4'b1110, 0, d, c);
    applyStimulus(MUL, 4'h0, 1, d, c);
`ifdef ALU_CTRL_MUL_EN
    checkOutput("mul_data", d, 8'h62);
    checkOutput("mul_acc_a", 8'(acc_a), 8'h06);
    checkOutput("mul_acc_b", 8'(acc_b), 8'h02);
`else
    checkOutput("mul_off_acc_a", 8'(acc_a), 8'h07);
    checkOutput("mul_off_acc_b", 8'(acc_b), 8'h0E);
`endif
    applyStimulus(LDA, 4'hF, 0, d, c);
    applyStimulus(LDB, 4'hF, 0, d, c);
    applyStimulus(MUL, 4'h0, 0, d, c);
    applyStimulus(LDA, 4'h0, 0, d, c);
    applyStimulus(LDB, 4'h9, 0, d, c);
    applyStimulus(MUL, 4'h0, 0, d, c);

    $display("[TB] illegal codes");
    applyStimulus(LDA, 4'h3, 0, d, c);
    applyStimulus(LDB, 4'h4, 0, d, c);
    applyStimulus(4'b1100, 4'hA, 0, d, c);
    checkOutput("illegal_acc_a", 8'(acc_a), 8'h03);
    checkOutput("illegal_ready", 8'(cmd_ready), 8'h01);
    applyStimulus(4'b1111, 4'hA, 0, d, c);

    $display("[TB] sweep of every ALU op");
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 3; p++) begin
        applyStimulus(LDA, xs[p], 0, d, c);
        applyStimulus(LDB, ys[p], 0, d, c);
        applyStimulus({1'b0, 3'(op)}, 4'h0, p, d, c);
      end
    end

    $display("[TB] back-to-back loads and swap");
    applyStimulus(LDA, 4'b0001, 0, d, c);
    applyStimulus(LDB, 4'b0011, 0, d, c);
    applyStimulus(SWAP, 4'h0, 0, d, c);
    checkOutput("swap_acc_a", 8'(acc_a), 8'h03);
    checkOutput("swap_acc_b", 8'(acc_b), 8'h01);

    $display("[TB] reset during operations");
    resetMid(4'b0101, 0);
    applyStimulus(LDA, 4'h6, 0, d, c);
    applyStimulus(LDB, 4'h5, 0, d, c);
    resetMid(4'b0101, 1);
`ifdef ALU_CTRL_MUL_EN
    applyStimulus(LDA, 4'h7, 0, d, c);
    applyStimulus(LDB, 4'hE, 0, d, c);
    resetMid(MUL, 1);
`endif
    applyStimulus(LDA, 4'hC, 0, d, c);
    checkOutput("post_reset_lda", 8'(acc_a), 8'h0C);
    tick();

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
